sm_muldiv: RTL
==============

# sm_muldiv

Parametrised iterative multiply/divide unit for the schoolMIPS core. It extends the single-cycle ALU with the MULT/MULTU/DIV/DIVU class of operations, producing a double-width result in HI/LO over multiple cycles. It sits beside the ALU in the execute path and uses a start/busy/done handshake. The control block stalls the PC while busy is high.

## Interface
- WIDTH, 32: operand width. HI and LO are each WIDTH bits. Must be at least 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- oper  in  2  operation: MD_MULTU=2'b00, MD_DIVU=2'b01, MD_MULT=2'b10, MD_DIV=2'b11.
- srcA  in  WIDTH  multiplicand / dividend.
- srcB  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo become valid.
- hi  out  WIDTH  upper product half / remainder.
- lo  out  WIDTH  lower product half / quotient.

## Operation
- States:
  - IDLE: on start, go to CALC.
  - CALC: runs WIDTH cycles, then goes to FIXUP when signed ops are compiled in, otherwise to DONE.
  - FIXUP: one cycle, then DONE.
  - DONE: one cycle, then IDLE.
- Load (edge that accepts start): latch operands as magnitudes, the sign flags, the op type and a div-by-zero flag (srcB==0). Set counter=WIDTH.
- Multiply (shift-add): accumulator {hi,lo} starts as {0, |srcB|}. Each CALC cycle: if lo[0], add |srcA| to hi with carry-out kept. Then shift {carry,hi,lo} right by 1.
- Divide (restoring): {rem,quot} starts as {0, |srcA|}. Each CALC cycle: shift left by 1. If rem ≥ |srcB|, subtract and set quot[0]=1. At the end, hi=rem and lo=quot.
- Divide by zero: result is forced to hi=srcA, lo=all ones. No sign fixup is applied. No exception.
- Signed fixup:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - MIN/−1 gives lo=MIN, hi=0.
- hi/lo hold their value until the next accepted start. They are not cleared at start; they are undefined during busy.
- start while busy: ignored, not queued.
- Arithmetic is modulo 2^WIDTH per half. The internal adder is WIDTH+1 bits.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0. The state machine goes to IDLE.
- start accepted at edge N:
  - busy=1 from edge N until edge N+WIDTH+1 (unsigned build) or N+WIDTH+2 (signed build).
  - done=1 for exactly the cycle following that final edge.
  - hi/lo are valid in the same cycle as done.
- Latency: WIDTH+1 cycles (unsigned build), or WIDTH+2 cycles (signed build, all ops including unsigned).
- busy and done are never high together.
- start in the done cycle: accepted, because the state returns to IDLE with that edge. Back-to-back throughput is one operation per latency+1 cycles.
- Reset asserted mid-operation: immediate return to IDLE. No done pulse; hi/lo are cleared.

## Configuration
- SM_MULDIV_SIGNED_EN defined:
  - MD_MULT and MD_DIV use two's-complement semantics.
  - The FIXUP state exists.
- Undefined:
  - The FIXUP state is removed.
  - MD_MULT/MD_DIV behave exactly as MD_MULTU/MD_DIVU.
  - Latency is WIDTH+1.

## Structure
- MD_* operation codes and the state encodings belong in the shared sm_cpu.vh, next to the ALU_* codes. The C_SPEC funct codes F_MULT/F_MULTU/F_DIV/F_DIVU also go there for the control decoder.
- One sub-module, sm_muldiv_step: a combinational single-iteration datapath. Inputs: op, accumulator, operand. Outputs: next accumulator. Instantiated once.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF (WIDTH=32): hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after start (unsigned build).
- DIVU 100/7: lo=14, hi=2. DIVU 0x1234/0: hi=0x1234, lo=0xFFFFFFFF.
- With SM_MULDIV_SIGNED_EN:
  - MULT −3×5: hi=0xFFFFFFFF, lo=0xFFFFFFF1. done 34 cycles after start.
  - DIV −7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- start pulsed while busy with different operands: ignored. The result matches the first operation only; single done pulse.
- rst asserted at cycle 10 of a DIVU: busy=0, hi=lo=0 at once, no done. A new MULTU 6×7 afterwards gives lo=42, hi=0.
- start held high continuously: operations complete back-to-back, with done pulses spaced latency+1 cycles apart.

Source files
------------

// File: rtl/sm_muldiv_pkg.sv
// Shared constants for the schoolMIPS iterative multiply/divide unit:
// operation codes, decoder funct codes and the controller state encoding.
package sm_muldiv_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  // C_SPEC funct field values the control decoder maps onto MD_* codes
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MD_S_IDLE  = 2'd0,
    MD_S_CALC  = 2'd1,
    MD_S_FIXUP = 2'd2,
    MD_S_DONE  = 2'd3
  } md_state_e;

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add multiply or
// restoring divide, sharing a single WIDTH+1 bit adder.
module sm_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH-1:0] hi_w;
  logic [WIDTH-1:0] lo_w;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             cin;
  logic [WIDTH+1:0] sum;
  logic             ge;

  always_comb begin
    hi_w  = acc_i[2*WIDTH-1:WIDTH];
    lo_w  = acc_i[WIDTH-1:0];
    add_a = {1'b0, hi_w};
    add_b = '0;
    cin   = 1'b0;
    if (div_i) begin
      // shifted remainder minus divisor; carry out means no borrow
      add_a = {hi_w, lo_w[WIDTH-1]};
      add_b = ~{1'b0, opnd_i};
      cin   = 1'b1;
    end else if (lo_w[0]) begin
      add_b = {1'b0, opnd_i};
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, cin};
    ge  = sum[WIDTH+1];
    if (div_i) begin
      acc_o = {(ge ? sum[WIDTH-1:0] : add_a[WIDTH-1:0]), lo_w[WIDTH-2:0], ge};
    end else begin
      acc_o = {sum[WIDTH:0], lo_w[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with start/busy/done handshake.
// Signed operation and the FIXUP state are compiled in with SM_MULDIV_SIGNED_EN.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is sampled only in IDLE; busy is high from the
  // accepting edge until the final edge, after which done pulses for one
  // cycle with hi/lo valid. The FSM is back in IDLE during that done cycle.

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SM_MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] acc_fix;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               dz_q;
  logic               a_neg_q;
  logic               b_neg_q;
  logic               busy_q;
  logic               done_q;

  logic               a_neg_d;
  logic               b_neg_d;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;

  always_comb begin
    a_neg_d = SIGNED_EN && oper[1] && srcA[WIDTH-1];
    b_neg_d = SIGNED_EN && oper[1] && srcB[WIDTH-1];
    a_mag_d = a_neg_d ? -srcA : srcA;
    b_mag_d = b_neg_d ? -srcB : srcB;
  end

  sm_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (is_div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_d)
  );

  // Quotient and product follow the sign XOR; remainder follows the dividend.
  always_comb begin
    acc_fix = acc_q;
    if (!is_div_q) begin
      if (a_neg_q ^ b_neg_q) acc_fix = -acc_q;
    end else begin
      if (a_neg_q) acc_fix[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
      if (a_neg_q ^ b_neg_q) acc_fix[WIDTH-1:0] = -acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_S_IDLE: begin
          if (start) begin
            state_q  <= MD_S_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(WIDTH);
            is_div_q <= oper[0];
            dz_q     <= (srcB == '0);
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            a_raw_q  <= srcA;
            if (oper[0]) begin
              acc_q  <= {{WIDTH{1'b0}}, a_mag_d};
              opnd_q <= b_mag_d;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, b_mag_d};
              opnd_q <= a_mag_d;
            end
          end
        end
        MD_S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
`ifdef SM_MULDIV_SIGNED_EN
            state_q <= MD_S_FIXUP;
`else
            state_q <= MD_S_DONE;
`endif
          end
        end
        MD_S_FIXUP: begin
          acc_q   <= acc_fix;
          state_q <= MD_S_DONE;
        end
        MD_S_DONE: begin
          state_q <= MD_S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (is_div_q && dz_q) begin
            hi_q <= a_raw_q;
            lo_q <= '1;
          end else begin
            hi_q <= acc_q[2*WIDTH-1:WIDTH];
            lo_q <= acc_q[WIDTH-1:0];
          end
        end
        default: state_q <= MD_S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule
